// File: rtl/pdp1_mem_arbiter.sv
// pdp1_mem_arbiter: two-port arbiter and sequencer for the 4K x 18 core memory.
// It shares one mm_* port between the CPU (port C) and the data-break channel
// (port D). Each access runs IDLE -> ACCESS -> DONE, so there is one access
// every three cycles. The CPU lock keeps read-modify-write sequences atomic.
// Optional feature macro: PDP1_MEMARB_RR_EN. When it is defined, ties between
// the ports are broken round-robin. When it is undefined, the CPU has fixed
// priority over the data-break channel.

`timescale 1ns/1ps

module pdp1_mem_arbiter #(
    parameter int AW = 12,
    parameter int DW = 18
) (
    input  logic          i_clk,
    input  logic          i_rst,

    input  logic          c_req,
    input  logic          c_we,
    input  logic          c_lock,
    input  logic [0:AW-1] c_adr,
    input  logic [0:DW-1] c_wdat,
    output logic          c_ack,
    output logic [0:DW-1] c_rdat,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [0:AW-1] d_adr,
    input  logic [0:DW-1] d_wdat,
    output logic          d_ack,
    output logic [0:DW-1] d_rdat,

    output logic          mm_we,
    output logic [0:AW-1] mm_adr,
    input  logic [0:DW-1] mm_din,
    output logic [0:DW-1] mm_dout,

    output logic          arb_busy,
    output logic          arb_owner
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t        state_q,    state_d;
    logic          mm_we_q,    mm_we_d;
    logic [0:AW-1] mm_adr_q,   mm_adr_d;
    logic [0:DW-1] mm_dout_q,  mm_dout_d;
    logic          c_ack_q,    c_ack_d;
    logic          d_ack_q,    d_ack_d;
    logic [0:DW-1] c_rdat_q,   c_rdat_d;
    logic [0:DW-1] d_rdat_q,   d_rdat_d;
    logic          owner_q,    owner_d;
    logic          lock_q,     lock_d;
    logic          lat_lock_q, lat_lock_d;
`ifdef PDP1_MEMARB_RR_EN
    logic          rr_q,       rr_d;
`endif

    logic          c_elig;
    logic          d_elig;
    logic          grant_any;
    logic          grant_d;

    // Decide which port may be granted in IDLE; the lock shuts out data break
    always_comb begin
        c_elig    = c_req;
        d_elig    = d_req & ~lock_q;
        grant_any = c_elig | d_elig;
`ifdef PDP1_MEMARB_RR_EN
        // rr_q == 0 means the CPU was granted last, so data break wins a tie
        grant_d   = d_elig & (~c_elig | ~rr_q);
`else
        grant_d   = d_elig & ~c_elig;
`endif
    end

    // Next-state and register updates for the three-phase memory cycle
    always_comb begin
        state_d    = state_q;
        mm_we_d    = mm_we_q;
        mm_adr_d   = mm_adr_q;
        mm_dout_d  = mm_dout_q;
        c_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        c_rdat_d   = c_rdat_q;
        d_rdat_d   = d_rdat_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        lat_lock_d = lat_lock_q;
`ifdef PDP1_MEMARB_RR_EN
        rr_d       = rr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d   = ST_ACCESS;
                    owner_d   = grant_d;
                    if (grant_d) begin
                        mm_we_d    = d_we;
                        mm_adr_d   = d_adr;
                        mm_dout_d  = d_wdat;
                        lat_lock_d = 1'b0;
                    end else begin
                        mm_we_d    = c_we;
                        mm_adr_d   = c_adr;
                        mm_dout_d  = c_wdat;
                        lat_lock_d = c_lock;
                    end
`ifdef PDP1_MEMARB_RR_EN
                    rr_d      = grant_d;
`endif
                end
            end

            ST_ACCESS: begin
                state_d = ST_DONE;
                mm_we_d = 1'b0;
                if (owner_q) begin
                    d_ack_d = 1'b1;
                    if (!mm_we_q) begin
                        d_rdat_d = mm_din;
                    end
                end else begin
                    c_ack_d = 1'b1;
                    if (!mm_we_q) begin
                        c_rdat_d = mm_din;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                if (!owner_q) begin
                    lock_d = lat_lock_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
                mm_we_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            mm_we_q    <= 1'b0;
            mm_adr_q   <= '0;
            mm_dout_q  <= '0;
            c_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            c_rdat_q   <= '0;
            d_rdat_q   <= '0;
            owner_q    <= 1'b0;
            lock_q     <= 1'b0;
            lat_lock_q <= 1'b0;
`ifdef PDP1_MEMARB_RR_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mm_we_q    <= mm_we_d;
            mm_adr_q   <= mm_adr_d;
            mm_dout_q  <= mm_dout_d;
            c_ack_q    <= c_ack_d;
            d_ack_q    <= d_ack_d;
            c_rdat_q   <= c_rdat_d;
            d_rdat_q   <= d_rdat_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            lat_lock_q <= lat_lock_d;
`ifdef PDP1_MEMARB_RR_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign mm_we     = mm_we_q;
    assign mm_adr    = mm_adr_q;
    assign mm_dout   = mm_dout_q;
    assign c_ack     = c_ack_q;
    assign d_ack     = d_ack_q;
    assign c_rdat    = c_rdat_q;
    assign d_rdat    = d_rdat_q;
    assign arb_owner = owner_q;
    assign arb_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pdp1_mem_arbiter.sv
// Testbench for pdp1_mem_arbiter. Directed scenarios run first. Randomized
// rounds follow and are checked against a slot-level model of arbitration,
// lock and memory contents. Honours PDP1_MEMARB_RR_EN for the tie-break rule.

`timescale 1ns/1ps

module tb_pdp1_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic        lock;
        logic [0:11] adr;
        logic [0:17] wdat;
    } txn_t;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        c_req, c_we, c_lock;
    logic [0:11] c_adr;
    logic [0:17] c_wdat;
    logic        c_ack;
    logic [0:17] c_rdat;
    logic        d_req, d_we;
    logic [0:11] d_adr;
    logic [0:17] d_wdat;
    logic        d_ack;
    logic [0:17] d_rdat;
    logic        mm_we;
    logic [0:11] mm_adr;
    logic [0:17] mm_din;
    logic [0:17] mm_dout;
    logic        arb_busy, arb_owner;

    logic [0:17] mem [0:4095];
    logic [0:17] ref_mem [0:4095];
    logic        pre_en = 1'b0;
    logic [0:11] pre_adr = '0;
    logic [0:17] pre_dat = '0;

    logic [0:11] addr_tab [0:7] = '{12'o0000, 12'o0001, 12'o0002, 12'o0100,
                                    12'o0200, 12'o3777, 12'o7776, 12'o7777};

    int          checks = 0;
    int          errors = 0;

    logic        m_lock;
    logic [0:17] m_crdat, m_drdat;
`ifdef PDP1_MEMARB_RR_EN
    logic        m_ptr;
`endif

    pdp1_mem_arbiter #(.AW(12), .DW(18)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_adr(c_adr),
        .c_wdat(c_wdat), .c_ack(c_ack), .c_rdat(c_rdat),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdat(d_wdat),
        .d_ack(d_ack), .d_rdat(d_rdat),
        .mm_we(mm_we), .mm_adr(mm_adr), .mm_din(mm_din), .mm_dout(mm_dout),
        .arb_busy(arb_busy), .arb_owner(arb_owner)
    );

    always #5 i_clk = ~i_clk;

    // Core memory model: combinational read, write on the clock edge
    assign mm_din = mem[mm_adr];

    // Memory writes from the DUT, or bench preloads while the DUT is idle
    always @(posedge i_clk) begin
        if (pre_en) mem[pre_adr] <= pre_dat;
        else if (mm_we) mem[mm_adr] <= mm_dout;
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_lock = 0; c_adr = '0; c_wdat = '0;
        d_req = 0; d_we = 0; d_adr = '0; d_wdat = '0;
    endtask

    task automatic drive_c(input logic we, input logic lock, input logic [0:11] adr, input logic [0:17] wdat);
        c_req = 1; c_we = we; c_lock = lock; c_adr = adr; c_wdat = wdat;
    endtask

    task automatic drive_d(input logic we, input logic [0:11] adr, input logic [0:17] wdat);
        d_req = 1; d_we = we; d_adr = adr; d_wdat = wdat;
    endtask

    task automatic preload(input logic [0:11] adr, input logic [0:17] dat);
        pre_en = 1; pre_adr = adr; pre_dat = dat;
        step();
        pre_en = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        i_rst = 1;
        step();
        i_rst = 0;
        m_lock = 0; m_crdat = '0; m_drdat = '0;
`ifdef PDP1_MEMARB_RR_EN
        m_ptr = 0;
`endif
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.we   = 1'($urandom_range(0, 1));
        t.lock = ($urandom_range(0, 2) == 0);
        t.adr  = addr_tab[$urandom_range(0, 7)];
        t.wdat = 18'($urandom_range(0, 18'h3ffff));
        return t;
    endfunction

    task automatic test_reset();
        reset_dut();
        checks++; if ({c_ack, d_ack, mm_we, arb_busy, arb_owner} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 00000", {c_ack, d_ack, mm_we, arb_busy, arb_owner});
        end
        checks++; if (mm_adr !== 12'o0) begin
            errors++; $display("[TB] FAIL reset_mm_adr: got %0o expected 0", mm_adr);
        end
        checks++; if (mm_dout !== 18'o0) begin
            errors++; $display("[TB] FAIL reset_mm_dout: got %0o expected 0", mm_dout);
        end
        checks++; if (c_rdat !== 18'o0 || d_rdat !== 18'o0) begin
            errors++; $display("[TB] FAIL reset_rdat: got %0o/%0o expected 0/0", c_rdat, d_rdat);
        end
    endtask

    task automatic test_cpu_read();
        int we_cnt = 0;
        preload(12'o0100, 18'o123456);
        drive_c(0, 0, 12'o0100, 18'o0);
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 3) c_req = 0;
            if (mm_we) we_cnt++;
            checks++; if (c_ack !== (cyc == 2)) begin
                errors++; $display("[TB] FAIL cpu_read_ack cyc%0d: got %b expected %b", cyc, c_ack, cyc == 2);
            end
            checks++; if (arb_busy !== (cyc == 1 || cyc == 2)) begin
                errors++; $display("[TB] FAIL cpu_read_busy cyc%0d: got %b", cyc, arb_busy);
            end
            if (cyc == 2) begin
                checks++; if (c_rdat !== 18'o123456) begin
                    errors++; $display("[TB] FAIL cpu_read_data: got %0o expected 123456", c_rdat);
                end
            end
            step();
        end
        checks++; if (we_cnt != 0) begin
            errors++; $display("[TB] FAIL cpu_read_no_we: got %0d write cycles expected 0", we_cnt);
        end
    endtask

    task automatic test_db_write_cpu_read();
        int we_cnt = 0;
        drive_d(1, 12'o0200, 18'o777777);
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc == 3) begin d_req = 0; drive_c(0, 0, 12'o0200, 18'o0); end
            if (cyc == 6) c_req = 0;
            if (mm_we) begin
                we_cnt++;
                checks++; if (mm_adr !== 12'o0200 || mm_dout !== 18'o777777) begin
                    errors++; $display("[TB] FAIL db_write_bus: got adr %0o data %0o expected 200/777777", mm_adr, mm_dout);
                end
            end
            checks++; if (d_ack !== (cyc == 2) || c_ack !== (cyc == 5)) begin
                errors++; $display("[TB] FAIL db_write_acks cyc%0d: got d%b c%b", cyc, d_ack, c_ack);
            end
            if (cyc == 2) begin
                checks++; if (arb_owner !== 1'b1) begin
                    errors++; $display("[TB] FAIL db_write_owner: got %b expected 1", arb_owner);
                end
            end
            if (cyc == 5) begin
                checks++; if (c_rdat !== 18'o777777 || arb_owner !== 1'b0) begin
                    errors++; $display("[TB] FAIL db_cpu_readback: got %0o owner %b expected 777777 owner 0", c_rdat, arb_owner);
                end
            end
            step();
        end
        checks++; if (we_cnt != 1) begin
            errors++; $display("[TB] FAIL db_write_we_count: got %0d expected 1", we_cnt);
        end
    endtask

    task automatic test_simultaneous();
        int ec, ed;
        reset_dut();
        preload(12'o0001, 18'o111111);
        preload(12'o0002, 18'o222222);
`ifdef PDP1_MEMARB_RR_EN
        ec = 5; ed = 2;
`else
        ec = 2; ed = 5;
`endif
        drive_c(0, 0, 12'o0001, 18'o0);
        drive_d(0, 12'o0002, 18'o0);
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc == ec + 1) c_req = 0;
            if (cyc == ed + 1) d_req = 0;
            checks++; if (c_ack !== (cyc == ec) || d_ack !== (cyc == ed)) begin
                errors++; $display("[TB] FAIL simul_acks cyc%0d: got c%b d%b expected c%b d%b", cyc, c_ack, d_ack, cyc == ec, cyc == ed);
            end
            if (cyc == 6) begin
                checks++; if (c_rdat !== 18'o111111 || d_rdat !== 18'o222222) begin
                    errors++; $display("[TB] FAIL simul_data: got %0o/%0o expected 111111/222222", c_rdat, d_rdat);
                end
            end
            step();
        end
    endtask

    task automatic test_lock();
        reset_dut();
        preload(12'o0300, 18'o055555);
        drive_c(0, 1, 12'o0300, 18'o0);
        for (int cyc = 0; cyc < 11; cyc++) begin
            if (cyc == 1) drive_d(0, 12'o0300, 18'o0);
            if (cyc == 3) drive_c(1, 0, 12'o0300, 18'o012345);
            if (cyc == 6) c_req = 0;
            if (cyc == 9) d_req = 0;
            checks++; if (c_ack !== (cyc == 2 || cyc == 5) || d_ack !== (cyc == 8)) begin
                errors++; $display("[TB] FAIL lock_acks cyc%0d: got c%b d%b", cyc, c_ack, d_ack);
            end
            if (cyc == 2) begin
                checks++; if (c_rdat !== 18'o055555) begin
                    errors++; $display("[TB] FAIL lock_cpu_read: got %0o expected 055555", c_rdat);
                end
            end
            if (cyc == 8) begin
                checks++; if (d_rdat !== 18'o012345) begin
                    errors++; $display("[TB] FAIL lock_db_read: got %0o expected 012345", d_rdat);
                end
            end
            step();
        end
    endtask

    task automatic test_held_request();
        int ack_cnt = 0, we_cnt = 0, busy_cnt = 0;
        drive_c(1, 0, 12'o0400, 18'o070707);
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc == 3) c_req = 0;
            if (c_ack) ack_cnt++;
            if (mm_we) we_cnt++;
            if (arb_busy) busy_cnt++;
            step();
        end
        checks++; if (ack_cnt != 1) begin
            errors++; $display("[TB] FAIL held_ack_count: got %0d expected 1", ack_cnt);
        end
        checks++; if (we_cnt != 1 || busy_cnt != 2) begin
            errors++; $display("[TB] FAIL held_access_count: got we %0d busy %0d expected 1/2", we_cnt, busy_cnt);
        end
        checks++; if (mem[12'o0400] !== 18'o070707) begin
            errors++; $display("[TB] FAIL held_mem: got %0o expected 070707", mem[12'o0400]);
        end
    endtask

    task automatic test_reset_mid();
        preload(12'o0500, 18'o135246);
        drive_c(0, 0, 12'o0500, 18'o0);
        step();
        i_rst = 1;
        step();
        i_rst = 0;
        c_req = 0;
        m_lock = 0; m_crdat = '0; m_drdat = '0;
`ifdef PDP1_MEMARB_RR_EN
        m_ptr = 0;
`endif
        checks++; if ({c_ack, d_ack, mm_we, arb_busy, arb_owner} !== 5'b0) begin
            errors++; $display("[TB] FAIL midreset_flags: got %b expected 00000", {c_ack, d_ack, mm_we, arb_busy, arb_owner});
        end
        checks++; if (mm_adr !== 12'o0 || c_rdat !== 18'o0) begin
            errors++; $display("[TB] FAIL midreset_regs: got adr %0o rdat %0o expected 0/0", mm_adr, c_rdat);
        end
        step();
        checks++; if (c_ack !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_no_ack: got %b expected 0", c_ack);
        end
        drive_c(0, 0, 12'o0500, 18'o0);
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (cyc == 3) c_req = 0;
            checks++; if (c_ack !== (cyc == 2)) begin
                errors++; $display("[TB] FAIL midreset_retry_ack cyc%0d: got %b", cyc, c_ack);
            end
            if (cyc == 2) begin
                checks++; if (c_rdat !== 18'o135246) begin
                    errors++; $display("[TB] FAIL midreset_retry_data: got %0o expected 135246", c_rdat);
                end
            end
            step();
        end
    endtask

    // One round: requests appear together; service is predicted slot by slot
    task automatic run_round();
        txn_t        ct, dt, rt, cur;
        bit          c_on, d_on, pc, pd, ec, ed, win_d, tie_d, c_seen, d_seen;
        int          rel_cyc, k, a, last;
        bit          exp_c [0:15];
        bit          exp_d [0:15];
        bit          c_rd [0:15];
        bit          d_rd [0:15];
        logic [0:17] c_val [0:15];
        logic [0:17] d_val [0:15];

        for (int i = 0; i < 16; i++) begin
            exp_c[i] = 0; exp_d[i] = 0; c_rd[i] = 0; d_rd[i] = 0;
            c_val[i] = '0; d_val[i] = '0;
        end
        c_on = ($urandom_range(0, 3) != 0);
        d_on = ($urandom_range(0, 3) != 0);
        if (!c_on && !d_on) d_on = 1;
        ct = rand_txn(); dt = rand_txn(); rt = rand_txn();
        rt.lock = 0;
        cur = ct; pc = c_on; pd = d_on; rel_cyc = -1; k = 0;

        while (pc || pd) begin
            ec = pc;
            ed = pd && !m_lock;
            if (!ec && !ed) begin
                cur = rt; pc = 1; ec = 1; rel_cyc = 3 * k;
            end
`ifdef PDP1_MEMARB_RR_EN
            tie_d = !m_ptr;
`else
            tie_d = 0;
`endif
            win_d = (ec && ed) ? tie_d : ed;
            a = 3 * k + 2;
            if (win_d) begin
                exp_d[a] = 1;
                if (!dt.we) begin d_rd[a] = 1; d_val[a] = ref_mem[dt.adr]; end
                else ref_mem[dt.adr] = dt.wdat;
                pd = 0;
`ifdef PDP1_MEMARB_RR_EN
                m_ptr = 1;
`endif
            end else begin
                exp_c[a] = 1;
                if (!cur.we) begin c_rd[a] = 1; c_val[a] = ref_mem[cur.adr]; end
                else ref_mem[cur.adr] = cur.wdat;
                m_lock = cur.lock;
                pc = 0;
`ifdef PDP1_MEMARB_RR_EN
                m_ptr = 0;
`endif
            end
            k++;
        end
        last = 3 * k - 1;

        c_seen = 0; d_seen = 0;
        for (int cyc = 0; cyc <= last; cyc++) begin
            if (c_seen) c_req = 0;
            if (d_seen) d_req = 0;
            if (cyc == 0 && c_on) drive_c(ct.we, ct.lock, ct.adr, ct.wdat);
            if (cyc == 0 && d_on) drive_d(dt.we, dt.adr, dt.wdat);
            if (cyc == rel_cyc) drive_c(rt.we, rt.lock, rt.adr, rt.wdat);
            if (exp_c[cyc] && c_rd[cyc]) m_crdat = c_val[cyc];
            if (exp_d[cyc] && d_rd[cyc]) m_drdat = d_val[cyc];
            checks++; if (c_ack !== exp_c[cyc] || d_ack !== exp_d[cyc]) begin
                errors++; $display("[TB] FAIL rand_acks cyc%0d: got c%b d%b expected c%b d%b", cyc, c_ack, d_ack, exp_c[cyc], exp_d[cyc]);
            end
            checks++; if (c_rdat !== m_crdat || d_rdat !== m_drdat) begin
                errors++; $display("[TB] FAIL rand_rdat cyc%0d: got %0o/%0o expected %0o/%0o", cyc, c_rdat, d_rdat, m_crdat, m_drdat);
            end
            c_seen = c_ack;
            d_seen = d_ack;
            step();
        end
        c_req = 0;
        d_req = 0;
    endtask

    task automatic test_random();
        logic [0:17] v;
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            v = 18'($urandom_range(0, 18'h3ffff));
            ref_mem[addr_tab[i]] = v;
            preload(addr_tab[i], v);
        end
        for (int r = 0; r < 60; r++) run_round();
    endtask

    initial begin
        idle_inputs();
        i_rst = 1;
        m_lock = 0; m_crdat = '0; m_drdat = '0;
`ifdef PDP1_MEMARB_RR_EN
        m_ptr = 0;
`endif
        #1;
        test_reset();
        test_cpu_read();
        test_db_write_cpu_read();
        test_simultaneous();
        test_lock();
        test_held_request();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
